stream_source: RTL and testbench
================================

STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 Parameter width_p, default 8: data width in bits, legal range 1..16.
REQ-002 Parameter beats_w_p, default 16: width of the beat count and the sent counter.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  begin a burst; sampled only in IDLE.
REQ-006 beats_i  input  beats_w_p  number of beats in the burst; latched on an accepted start.
REQ-007 gap_i  input  4  idle cycles inserted after each accepted beat; latched on an accepted start.
REQ-008 abort_i  input  1  request early termination of the burst.
REQ-009 data_o  output  width_p  payload to the downstream consumer.
REQ-010 valid_o  output  1  payload valid.
REQ-011 ready_i  input  1  downstream ready; a transfer occurs on a cycle with valid_o=1 and ready_i=1.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle pulse when a burst ends, whether completed or aborted.
REQ-014 sent_o  output  beats_w_p  number of transfers since the last accepted start.

Function
REQ-015 The block SHALL implement four states:
- IDLE
- SEND: valid_o=1.
- GAP: valid_o=0.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
REQ-016 In IDLE, start_i=1 with beats_i!=0 SHALL latch beats_i and gap_i, clear sent_o, and enter SEND on the next cycle.
REQ-017 In IDLE, start_i=1 with beats_i=0 SHALL be ignored: no state change and no done_o.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 Once valid_o rises, valid_o and data_o SHALL hold stable until the transfer cycle.
REQ-020 On each transfer:
- sent_o increments.
- the remaining count decrements.
- the data generator advances one step.
REQ-021 After a transfer, the next state SHALL be:
- DONE if the remaining count reaches 0;
- otherwise SEND if the latched gap=0, giving one beat per cycle while ready_i=1;
- otherwise GAP for exactly the latched gap cycles, then SEND.
REQ-022 abort_i in GAP SHALL go to DONE on the next cycle.
REQ-023 abort_i in SEND SHALL be registered as pending, SHALL NOT drop valid_o, and the block SHALL go to DONE after the next transfer.
REQ-024 abort_i in IDLE or DONE SHALL have no effect.
REQ-025 A pending abort SHALL be cleared on entry to IDLE.
REQ-026 If the final beat's transfer coincides with abort_i, the block SHALL reach DONE exactly once.
REQ-027 sent_o SHALL hold its final value in IDLE until the next accepted start.
REQ-028 The counter wraps at 2^beats_w_p; beats_i=2^beats_w_p-1 SHALL complete without overflow.
REQ-029 The data sequence SHALL restart from its initial value on every accepted start.
REQ-030 Latency from start_i to first valid_o SHALL be 1 cycle.
REQ-031 Latency from the last transfer to done_o SHALL be 1 cycle.

Reset
REQ-032 While reset_ni=0, the following SHALL hold immediately, without waiting for a clock edge:
- state=IDLE
- valid_o=0, busy_o=0, done_o=0
- sent_o=0, data_o=0
- pending abort cleared
REQ-033 Reset deassertion mid-burst SHALL resume from IDLE; no partial burst continues.

Configuration
REQ-034 With macro STREAM_SOURCE_LFSR_EN defined, data SHALL come from a 16-bit Fibonacci LFSR:
- polynomial x^16+x^14+x^13+x^11+1
- seed 16'hACE1
- data_o = low width_p bits of the LFSR state
- one LFSR step per transfer
REQ-035 Without STREAM_SOURCE_LFSR_EN, data SHALL be a width_p-bit up-counter: starts at 0, increments by 1 per transfer, wraps at 2^width_p.

Structure
REQ-036 Package stream_source_pkg SHALL hold:
- the state enum
- LFSR width, taps and seed constants
- the gap field width
REQ-037 The LFSR SHALL be a separate sub-module, stream_source_lfsr (inputs: clock, reset, load, step; output: state), instantiated only under STREAM_SOURCE_LFSR_EN.

Verification
REQ-038 Counter build, beats_i=4, gap_i=0, ready_i=1 constantly -> data_o 0,1,2,3 on consecutive cycles; done_o 1 cycle after the 4th transfer; sent_o=4.
REQ-039 beats_i=3, gap_i=2, ready_i=1 -> valid_o pattern 1,0,0,1,0,0,1, then done_o; valid_o never high in GAP.
REQ-040 beats_i=2, ready_i low for 5 cycles after valid_o rises -> data_o stays 0 and valid_o stays 1 throughout; transfer on the first cycle ready_i=1.
REQ-041 beats_i=10, abort_i pulsed while valid_o=1 and ready_i=0, ready_i raised 3 cycles later -> exactly 1 further transfer, then done_o; sent_o=1.
REQ-042 LFSR build, beats_i=3, width_p=16 -> data_o ACE1, 5670, AB38 (per REQ-034 polynomial); a restart repeats ACE1.
REQ-043 reset_ni driven low asynchronously mid-burst (sent_o=2) -> valid_o, busy_o and sent_o drop to 0 before the next clock edge; start_i is honoured after reset release.

Source files
------------

// File: rtl/stream_source_pkg.sv
// Shared types and constants for the stream_source burst generator.
// The LFSR constants are only consumed when STREAM_SOURCE_LFSR_EN is defined.
package stream_source_pkg;

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of the inter-beat gap field
    localparam int GAP_W = 4;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    // Polynomial exponent e maps to state bit (16 - e): taps at bits 0, 2, 3, 5.
    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    // One LFSR step: new MSB is the XOR of the tapped bits, the rest shift right
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/stream_source_lfsr.sv
// 16-bit Fibonacci LFSR used as the payload generator of stream_source.
// Resets to all-zero so the payload reads 0 while in reset; the seed is
// loaded explicitly at the start of every burst.
module stream_source_lfsr
    import stream_source_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;

    // Seed on load, advance one step per accepted beat, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= LFSR_SEED;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/stream_source.sv
// stream_source: emits bursts of beats_i valid/ready beats with gap_i idle
// cycles between beats, with abort support and a transfer counter.
// Build option: define STREAM_SOURCE_LFSR_EN to take the payload from a
// 16-bit LFSR (stream_source_lfsr); otherwise the payload is an up-counter.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int width_p   = 8,
    parameter int beats_w_p = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [beats_w_p-1:0] beats_i,
    input  logic [GAP_W-1:0]     gap_i,
    input  logic                 abort_i,
    output logic [width_p-1:0]   data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [beats_w_p-1:0] sent_o
);

    localparam logic [beats_w_p-1:0] LP_BEATS_ONE = beats_w_p'(1);
    localparam logic [GAP_W-1:0]     LP_GAP_ONE   = GAP_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [beats_w_p-1:0] r_remaining;
    logic [beats_w_p-1:0] r_sent;
    logic [GAP_W-1:0]     r_gap_len;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_abort_pend;

    logic                 w_start_acc;
    logic                 w_xfer;
    logic                 w_end_burst;

    // A start is only honoured in IDLE and only for a non-empty burst
    assign w_start_acc = (r_state == ST_IDLE) && start_i && (beats_i != '0);
    assign w_xfer      = (r_state == ST_SEND) && ready_i;
    // The beat being transferred closes the burst if it is the last one or
    // an abort is pending / arriving together with it
    assign w_end_burst = (r_remaining == LP_BEATS_ONE) || r_abort_pend || abort_i;

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (w_end_burst) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_gap_len == '0) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else if (r_gap_cnt == LP_GAP_ONE) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: latched config, remaining/sent counters, gap timer
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_remaining <= '0;
            r_sent      <= '0;
            r_gap_len   <= '0;
            r_gap_cnt   <= '0;
        end else if (w_start_acc) begin
            r_remaining <= beats_i;
            r_gap_len   <= gap_i;
            r_sent      <= '0;
        end else if (w_xfer) begin
            r_remaining <= r_remaining - LP_BEATS_ONE;
            r_sent      <= r_sent + LP_BEATS_ONE;
            r_gap_cnt   <= r_gap_len;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt   <= r_gap_cnt - LP_GAP_ONE;
        end
    end

    // Abort seen while a beat is stalled is remembered until the beat goes;
    // it is dropped when the block returns to IDLE
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_abort_pend <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_abort_pend <= 1'b0;
        end else if ((r_state == ST_SEND) && abort_i && !w_xfer) begin
            r_abort_pend <= 1'b1;
        end
    end

`ifdef STREAM_SOURCE_LFSR_EN
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_unused_lfsr_hi;

    stream_source_lfsr u_lfsr (
        .i_clk   (clk_i),
        .i_rst_n (reset_ni),
        .i_load  (w_start_acc),
        .i_step  (w_xfer),
        .o_state (w_lfsr)
    );

    assign data_o           = w_lfsr[width_p-1:0];
    assign w_unused_lfsr_hi = ^w_lfsr;
`else
    logic [width_p-1:0] r_data;

    // Payload up-counter: restarts at 0 on each burst, steps per transfer
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_data <= '0;
        end else if (w_start_acc) begin
            r_data <= '0;
        end else if (w_xfer) begin
            r_data <= r_data + width_p'(1);
        end
    end

    assign data_o = r_data;
`endif

    assign valid_o = (r_state == ST_SEND);
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = (r_state == ST_DONE);
    assign sent_o  = r_sent;

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source (either payload build).
module tb_stream_source;

    localparam int WIDTH = 4;
    localparam int BW    = 8;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             start_i;
    logic [BW-1:0]    beats_i;
    logic [3:0]       gap_i;
    logic             abort_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             busy_o;
    logic             done_o;
    logic [BW-1:0]    sent_o;

    int n_checks = 0;
    int n_errors = 0;

    stream_source #(.width_p(WIDTH), .beats_w_p(BW)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .beats_i  (beats_i),
        .gap_i    (gap_i),
        .abort_i  (abort_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .sent_o   (sent_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Payload of the k-th beat of a burst, straight from the data rules
    function automatic int exp_data(input int k);
`ifdef STREAM_SOURCE_LFSR_EN
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return int'(s) % (1 << WIDTH);
`else
        return k % (1 << WIDTH);
`endif
    endfunction

    task automatic do_start(input int beats, input int gap);
        start_i = 1'b1;
        beats_i = beats[BW-1:0];
        gap_i   = gap[3:0];
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Scoreboarded burst with random backpressure
    task automatic run_burst(input int beats, input int gap, input int rdy_pct);
        int xf, low, cyc;
        bit after_xfer, prev_hold;
        xf = 0; low = 0; cyc = 0; after_xfer = 0; prev_hold = 0;
        do_start(beats, gap);
        chk("first_valid", int'(valid_o), 1);
        while (xf < beats && cyc < 4000) begin
            cyc++;
            chk("busy", int'(busy_o), 1);
            chk("done_early", int'(done_o), 0);
            chk("sent", int'(sent_o), xf % (1 << BW));
            if (prev_hold) chk("hold_valid", int'(valid_o), 1);
            if (valid_o) begin
                if (after_xfer) begin
                    chk("gap_len", low, gap);
                    after_xfer = 0;
                end
                chk("data", int'(data_o), exp_data(xf));
            end else begin
                low++;
            end
            ready_i   = ($urandom_range(0, 99) < rdy_pct);
            prev_hold = valid_o && !ready_i;
            if (valid_o && ready_i) begin
                xf++;
                after_xfer = 1;
                low = 0;
            end
            @(negedge clk_i);
        end
        if (xf < beats) chk("burst_timeout", xf, beats);
        chk("done_pulse", int'(done_o), 1);
        chk("valid_in_done", int'(valid_o), 0);
        chk("sent_final", int'(sent_o), beats);
        ready_i = 1'b0;
        @(negedge clk_i);
        chk("idle_busy", int'(busy_o), 0);
        chk("done_once", int'(done_o), 0);
        chk("sent_hold", int'(sent_o), beats);
    endtask

    typedef struct {
        int beats;
        int gap;
        int exp_done_cyc;
        int exp_valid_cnt;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int cyc, nval;

        reset_ni = 1'b0; start_i = 1'b0; beats_i = '0; gap_i = '0;
        abort_i = 1'b0; ready_i = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_sent", int'(sent_o), 0);
        chk("rst_data", int'(data_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // Table: ready held high; cycle 1 is the first cycle after the start edge
        vecs[0] = '{4, 0, 5, 4};
        vecs[1] = '{3, 2, 8, 3};
        vecs[2] = '{1, 0, 2, 1};
        vecs[3] = '{2, 15, 18, 2};
        vecs[4] = '{5, 1, 10, 5};
        vecs[5] = '{1, 9, 2, 1};
        ready_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            do_start(vecs[v].beats, vecs[v].gap);
            cyc = 1; nval = 0;
            while (!done_o && cyc < 64) begin
                if (valid_o) nval++;
                @(negedge clk_i);
                cyc++;
            end
            chk($sformatf("vec%0d_done_cyc", v), cyc, vecs[v].exp_done_cyc);
            chk($sformatf("vec%0d_valid_cnt", v), nval, vecs[v].exp_valid_cnt);
            chk($sformatf("vec%0d_sent", v), int'(sent_o), vecs[v].beats);
            @(negedge clk_i);
        end

        // Four back-to-back beats carry consecutive payloads
        do_start(4, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_valid%0d", k), int'(valid_o), 1);
            chk($sformatf("b2b_data%0d", k), int'(data_o), exp_data(k));
            @(negedge clk_i);
        end
        chk("b2b_done", int'(done_o), 1);
        chk("b2b_sent", int'(sent_o), 4);
        @(negedge clk_i);

        // Stall: ready low for 5 cycles once valid rises
        ready_i = 1'b0;
        do_start(2, 0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", int'(valid_o), 1);
            chk("stall_data", int'(data_o), exp_data(0));
            chk("stall_sent", int'(sent_o), 0);
            if (k < 4) @(negedge clk_i);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("stall_sent1", int'(sent_o), 1);
        chk("stall_data1", int'(data_o), exp_data(1));
        @(negedge clk_i);
        chk("stall_done", int'(done_o), 1);
        chk("stall_sent2", int'(sent_o), 2);
        @(negedge clk_i);

        // Abort while stalled: one more beat, then done
        ready_i = 1'b0;
        do_start(10, 0);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_keep_valid", int'(valid_o), 1);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_keep_valid2", int'(valid_o), 1);
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("abort_done", int'(done_o), 1);
        chk("abort_sent", int'(sent_o), 1);
        chk("abort_valid", int'(valid_o), 0);
        @(negedge clk_i);
        chk("abort_idle", int'(busy_o), 0);

        // Abort during a gap ends the burst on the next cycle
        do_start(5, 3);
        @(negedge clk_i);
        chk("gapabort_in_gap", int'(valid_o), 0);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("gapabort_done", int'(done_o), 1);
        chk("gapabort_sent", int'(sent_o), 1);
        @(negedge clk_i);

        // Abort coinciding with the final beat: a single done pulse
        do_start(2, 0);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("lastabort_done", int'(done_o), 1);
        @(negedge clk_i);
        chk("lastabort_done_off", int'(done_o), 0);
        chk("lastabort_idle", int'(busy_o), 0);
        @(negedge clk_i);
        chk("lastabort_no_redo", int'(done_o), 0);
        chk("lastabort_sent", int'(sent_o), 2);

        // Zero-beat start is ignored
        do_start(0, 0);
        chk("zero_busy", int'(busy_o), 0);
        @(negedge clk_i);
        chk("zero_done", int'(done_o), 0);
        chk("zero_sent", int'(sent_o), 2);

        // Start held high during a burst is ignored
        do_start(3, 1);
        start_i = 1'b1; beats_i = 8'd7;
        cyc = 1;
        while (!done_o && cyc < 64) begin
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        chk("busystart_done_cyc", cyc, 6);
        chk("busystart_sent", int'(sent_o), 3);
        @(negedge clk_i);

        // Abort in IDLE has no effect on the following burst
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("idleabort_busy", int'(busy_o), 0);
        run_burst(3, 0, 100);

        // Randomized bursts against the scoreboard
        for (int r = 0; r < 10; r++) begin
            run_burst(int'($urandom_range(1, 9)), int'($urandom_range(0, 3)),
                      int'($urandom_range(30, 100)));
        end

        // Largest beat count for the counter width
        run_burst((1 << BW) - 1, 0, 80);

        // Asynchronous reset mid-burst
        ready_i = 1'b1;
        do_start(6, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("midrst_sent_before", int'(sent_o), 2);
        #1 reset_ni = 1'b0;
        #1;
        chk("midrst_valid", int'(valid_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_sent", int'(sent_o), 0);
        chk("midrst_data", int'(data_o), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_no_resume", int'(busy_o), 0);
        run_burst(3, 1, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
